pkt_len_meter: RTL and testbench
================================

# pkt_len_meter

Per-packet length meter upstream of `stat_prj`. It watches the ingress packet stream, accumulates the byte count of each packet, and filters aborted, errored and malformed traffic. For each good packet it emits exactly one `rx_flow_num_o`/`pkt_size_o`/`pkt_size_en_o` record, which connects directly to the statistics block's `rx_flow_num_i`/`pkt_size_i`/`pkt_size_en_i`.

## Interface
- `A_WIDTH`, 10, flow-number width; must match `stat_prj`.
- `DATA_BYTES`, 8, bytes per bus beat; power of two, 2..64.
- `EMPTY_W`, `$clog2(DATA_BYTES)`, width of `pkt_empty_i`.
- `MIN_LEN`, 64, runt threshold in bytes; used only with `PKT_LEN_METER_RUNT_EN`.

Ports:
- `clk_i`  in  1  single clock, all logic on its rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `pkt_valid_i`  in  1  beat qualifier; all other `pkt_*` inputs are ignored when low.
- `pkt_sop_i`  in  1  first beat of packet.
- `pkt_eop_i`  in  1  last beat of packet; may coincide with sop.
- `pkt_empty_i`  in  `EMPTY_W`  unused bytes in the eop beat; ignored on other beats.
- `pkt_err_i`  in  1  packet errored; sampled on the eop beat only.
- `pkt_flow_i`  in  `A_WIDTH`  flow number; sampled on the sop beat only.
- `rx_flow_num_o`  out  `A_WIDTH`  flow of the emitted record.
- `pkt_size_o`  out  16  byte length of the emitted record.
- `pkt_size_en_o`  out  1  one-cycle record strobe.
- `err_cnt_o`  out  16  saturating protocol/error event count.
- `runt_cnt_o`  out  16  saturating runt drop count.

## Operation
- FSM states:
  - IDLE; on reset entry, IDLE.
  - IN_PKT.
- IDLE transitions:
  - valid&sop&eop: emit a record, stay IDLE.
  - valid&sop&!eop: latch flow, len=DATA_BYTES, go to IN_PKT.
  - valid&!sop: protocol error, err_cnt+1, beat ignored.
- IN_PKT transitions:
  - valid&!sop&!eop: len += DATA_BYTES.
  - valid&!sop&eop: len += DATA_BYTES − empty, emit a record, go to IDLE.
  - valid&sop: abort the current packet with no record, err_cnt+1; the sop beat then starts a new packet with the same rules as IDLE.
- Length arithmetic:
  - 17-bit internal accumulator.
  - The final value saturates to 16'hFFFF and never wraps.
  - Single-beat length = DATA_BYTES − empty.
- Record emission:
  - Suppressed if `pkt_err_i`=1 on the eop beat; this counts err_cnt+1.
  - Suppressed for runts (see Configuration).
- Counters:
  - Both counters hold at 16'hFFFF once saturated.
  - A single beat increments `err_cnt_o` by at most 1.
- Stream handling:
  - No backpressure; the block accepts one beat per cycle indefinitely.
  - `pkt_flow_i` and `pkt_empty_i` on non-qualifying beats have no effect.

## Timing
- Record latency: `pkt_size_en_o`=1 exactly one cycle after the eop beat. It is a single-cycle pulse, and `rx_flow_num_o`/`pkt_size_o` are valid in that same cycle.
- Record outputs are registered and hold their last value when `pkt_size_en_o`=0.
- Throughput: back-to-back single-beat packets produce `pkt_size_en_o` high every cycle.
- Counters update one cycle after the offending beat.
- Reset values: `rx_flow_num_o`=0, `pkt_size_o`=0, `pkt_size_en_o`=0, `err_cnt_o`=0, `runt_cnt_o`=0.
- Reset mid-packet: the packet is discarded with no record, and the FSM returns to IDLE. A continuation beat after release counts as a protocol error.

## Configuration
- `PKT_LEN_METER_RUNT_EN` defined:
  - Packets with final length < `MIN_LEN` produce no record.
  - Each such packet increments `runt_cnt_o` once.
  - An errored runt counts only in `err_cnt_o`.
- Undefined:
  - All non-errored packets produce records regardless of length.
  - `runt_cnt_o` is tied to 0.

## Test plan
- 10-beat packet, flow 3, empty 2 on eop → one cycle after eop: en=1, flow=3, size=78; counters 0.
- Two back-to-back 8-beat packets, flows 1 then 2, empty 0 → two en pulses 8 cycles apart, each with size=64 and the correct flow.
- sop flow 9 + 2 beats, then sop flow 5 + 8 more beats, eop empty 0 → a single record (flow=5, size=72) and err_cnt=1.
- 8200-beat packet → size=16'hFFFF. Separately, a valid non-sop beat in IDLE → err_cnt+1 and no record.
- Single beat sop&eop, flow 4, empty 3:
  - with macro → no record, runt_cnt=1;
  - without macro → record with size=5, flow=4.
- `rst_i` low for 2 cycles mid-packet → all outputs 0, no record. A subsequent eop-only beat → err_cnt=1.

Source files
------------

// File: rtl/pkt_len_meter.sv
// rtl/pkt_len_meter.sv - per-packet byte length meter feeding stat_prj records
// Optional runt filtering is enabled by defining PKT_LEN_METER_RUNT_EN.
module pkt_len_meter #(
  parameter int A_WIDTH    = 10,
  parameter int DATA_BYTES = 8,
  parameter int EMPTY_W    = $clog2(DATA_BYTES),
  parameter int MIN_LEN    = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pkt_valid_i,
  input  logic               pkt_sop_i,
  input  logic               pkt_eop_i,
  input  logic [EMPTY_W-1:0] pkt_empty_i,
  input  logic               pkt_err_i,
  input  logic [A_WIDTH-1:0] pkt_flow_i,
  output logic [A_WIDTH-1:0] rx_flow_num_o,
  output logic [15:0]        pkt_size_o,
  output logic               pkt_size_en_o,
  output logic [15:0]        err_cnt_o,
  output logic [15:0]        runt_cnt_o
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  localparam logic [16:0] BEAT_BYTES = 17'(DATA_BYTES);
  localparam logic [16:0] LEN_CAP    = 17'h10000;
`ifdef PKT_LEN_METER_RUNT_EN
  localparam logic [16:0] RUNT_LIMIT = 17'(MIN_LEN);
`else
  localparam logic [16:0] RUNT_LIMIT = 17'(MIN_LEN) & 17'h0;
`endif

  state_t             state_q, state_d;
  logic [16:0]        len_q, len_d;
  logic [A_WIDTH-1:0] flow_q, flow_d;
  logic [16:0]        eop_bytes, sum_mid, sum_eop;
  logic               eop_hit, proto_err;
  logic [16:0]        fin_len;
  logic [A_WIDTH-1:0] fin_flow;
  logic [15:0]        fin_size;
  logic               is_runt, emit, err_inc;

  // Accumulator parks at 0x10000 once past 16 bits, so later adds cannot wrap it.
  function automatic logic [16:0] cap_len(input logic [16:0] v);
    return v[16] ? LEN_CAP : v;
  endfunction

  assign eop_bytes = BEAT_BYTES - 17'(pkt_empty_i);
  assign sum_mid   = len_q + BEAT_BYTES;
  assign sum_eop   = len_q + eop_bytes;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (pkt_valid_i) begin
      if (pkt_sop_i)                              state_d = pkt_eop_i ? IDLE : IN_PKT;
      else if (state_q == IN_PKT && pkt_eop_i)    state_d = IDLE;
    end
  end

  always_comb begin
    len_d     = len_q;
    flow_d    = flow_q;
    eop_hit   = 1'b0;
    proto_err = 1'b0;
    fin_len   = '0;
    fin_flow  = flow_q;
    if (pkt_valid_i) begin
      if (pkt_sop_i) begin
        // A sop while inside a packet aborts it; the sop still opens a new one.
        proto_err = (state_q == IN_PKT);
        flow_d    = pkt_flow_i;
        if (pkt_eop_i) begin
          eop_hit  = 1'b1;
          fin_len  = eop_bytes;
          fin_flow = pkt_flow_i;
        end else begin
          len_d = BEAT_BYTES;
        end
      end else if (state_q == IN_PKT) begin
        if (pkt_eop_i) begin
          eop_hit = 1'b1;
          fin_len = cap_len(sum_eop);
        end else begin
          len_d = cap_len(sum_mid);
        end
      end else begin
        proto_err = 1'b1;
      end
    end
  end

  assign fin_size = fin_len[16] ? 16'hFFFF : fin_len[15:0];
  assign is_runt  = eop_hit && !pkt_err_i && (fin_len < RUNT_LIMIT);
  assign emit     = eop_hit && !pkt_err_i && !is_runt;
  assign err_inc  = proto_err || (eop_hit && pkt_err_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      len_q  <= '0;
      flow_q <= '0;
    end else begin
      len_q  <= len_d;
      flow_q <= flow_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_flow_num_o <= '0;
      pkt_size_o    <= '0;
      pkt_size_en_o <= 1'b0;
    end else begin
      pkt_size_en_o <= emit;
      if (emit) begin
        rx_flow_num_o <= fin_flow;
        pkt_size_o    <= fin_size;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                              err_cnt_o <= '0;
    else if (err_inc && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
  end

`ifdef PKT_LEN_METER_RUNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                               runt_cnt_o <= '0;
    else if (is_runt && runt_cnt_o != 16'hFFFF) runt_cnt_o <= runt_cnt_o + 16'd1;
  end
`else
  assign runt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pkt_len_meter.sv
// tb/tb_pkt_len_meter.sv - directed self-checking bench for pkt_len_meter
module tb_pkt_len_meter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       pkt_valid_i = 1'b0;
  logic       pkt_sop_i = 1'b0;
  logic       pkt_eop_i = 1'b0;
  logic [2:0] pkt_empty_i = '0;
  logic       pkt_err_i = 1'b0;
  logic [9:0] pkt_flow_i = '0;
  logic [9:0] rx_flow_num_o;
  logic [15:0] pkt_size_o;
  logic       pkt_size_en_o;
  logic [15:0] err_cnt_o;
  logic [15:0] runt_cnt_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rec_cnt = 0;
  int rec_base;
  int pulses[$];

  pkt_len_meter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pkt_valid_i(pkt_valid_i), .pkt_sop_i(pkt_sop_i), .pkt_eop_i(pkt_eop_i),
    .pkt_empty_i(pkt_empty_i), .pkt_err_i(pkt_err_i), .pkt_flow_i(pkt_flow_i),
    .rx_flow_num_o(rx_flow_num_o), .pkt_size_o(pkt_size_o), .pkt_size_en_o(pkt_size_en_o),
    .err_cnt_o(err_cnt_o), .runt_cnt_o(runt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (pkt_size_en_o) begin
      rec_cnt++;
      pulses.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic beat(input logic v, input logic s, input logic e, input logic [2:0] em,
                      input logic er, input logic [9:0] fl);
    pkt_valid_i = v;
    pkt_sop_i   = s;
    pkt_eop_i   = e;
    pkt_empty_i = em;
    pkt_err_i   = er;
    pkt_flow_i  = fl;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 10'd0);
  endtask

  task automatic pkt(input logic [9:0] fl, input int nbeats, input logic [2:0] em);
    if (nbeats == 1) begin
      beat(1'b1, 1'b1, 1'b1, em, 1'b0, fl);
    end else begin
      beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, fl);
      for (int i = 0; i < nbeats - 2; i++) beat(1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 10'h3FF);
      beat(1'b1, 1'b0, 1'b1, em, 1'b0, 10'h2AA);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_flow", rx_flow_num_o, 0);
    check("rst_size", pkt_size_o, 0);
    check("rst_en", pkt_size_en_o, 0);
    check("rst_err", err_cnt_o, 0);
    check("rst_runt", runt_cnt_o, 0);
    rst_i = 1'b1;
    idle();

    // 10 beats, empty 2 -> 78 bytes
    rec_base = rec_cnt;
    pkt(10'd3, 10, 3'd2);
    check("p10_en", pkt_size_en_o, 1);
    check("p10_flow", rx_flow_num_o, 3);
    check("p10_size", pkt_size_o, 78);
    check("p10_err", err_cnt_o, 0);
    idle();
    check("p10_pulse_end", pkt_size_en_o, 0);
    check("p10_hold_size", pkt_size_o, 78);
    check("p10_recs", rec_cnt - rec_base, 1);

    // two back-to-back 8-beat packets
    rec_base = rec_cnt;
    pkt(10'd1, 8, 3'd0);
    check("b2b1_en", pkt_size_en_o, 1);
    check("b2b1_flow", rx_flow_num_o, 1);
    check("b2b1_size", pkt_size_o, 64);
    pkt(10'd2, 8, 3'd0);
    check("b2b2_en", pkt_size_en_o, 1);
    check("b2b2_flow", rx_flow_num_o, 2);
    check("b2b2_size", pkt_size_o, 64);
    idle();
    check("b2b_recs", rec_cnt - rec_base, 2);
    check("b2b_spacing", pulses[pulses.size()-1] - pulses[pulses.size()-2], 8);

    // abort by early sop
    rec_base = rec_cnt;
    beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 10'd9);
    beat(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 10'd0);
    beat(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 10'd0);
    pkt(10'd5, 9, 3'd0);
    check("abort_flow", rx_flow_num_o, 5);
    check("abort_size", pkt_size_o, 72);
    check("abort_err", err_cnt_o, 1);
    idle();
    check("abort_recs", rec_cnt - rec_base, 1);

    // 8200 beats saturates the length
    pkt(10'd7, 8200, 3'd0);
    check("long_en", pkt_size_en_o, 1);
    check("long_size", pkt_size_o, 16'hFFFF);
    check("long_flow", rx_flow_num_o, 7);
    idle();

    // continuation beat in IDLE
    rec_base = rec_cnt;
    beat(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 10'd1);
    check("idle_cont_err", err_cnt_o, 2);
    check("idle_cont_en", pkt_size_en_o, 0);
    idle();
    check("idle_cont_recs", rec_cnt - rec_base, 0);

    // single-beat packet, 5 bytes
    rec_base = rec_cnt;
    pkt(10'd4, 1, 3'd3);
`ifdef PKT_LEN_METER_RUNT_EN
    check("runt_en", pkt_size_en_o, 0);
    check("runt_cnt", runt_cnt_o, 1);
    idle();
    check("runt_recs", rec_cnt - rec_base, 0);
`else
    check("single_en", pkt_size_en_o, 1);
    check("single_size", pkt_size_o, 5);
    check("single_flow", rx_flow_num_o, 4);
    check("single_runt", runt_cnt_o, 0);
    idle();
    check("single_recs", rec_cnt - rec_base, 1);
`endif

    // errored packet: no record, err count, outputs hold
    rec_base = rec_cnt;
    beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 10'd12);
    beat(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 10'd0);
    check("errpkt_en", pkt_size_en_o, 0);
    check("errpkt_err", err_cnt_o, 3);
`ifdef PKT_LEN_METER_RUNT_EN
    check("errpkt_hold", pkt_size_o, 16'hFFFF);
    check("errpkt_hold_flow", rx_flow_num_o, 7);
`else
    check("errpkt_hold", pkt_size_o, 5);
    check("errpkt_hold_flow", rx_flow_num_o, 4);
`endif
    idle();
    check("errpkt_recs", rec_cnt - rec_base, 0);

    // back-to-back single-beat packets
    pkt(10'd6, 1, 3'd0);
`ifndef PKT_LEN_METER_RUNT_EN
    check("tp0_en", pkt_size_en_o, 1);
    check("tp0_flow", rx_flow_num_o, 6);
`endif
    pkt(10'd7, 1, 3'd0);
`ifndef PKT_LEN_METER_RUNT_EN
    check("tp1_en", pkt_size_en_o, 1);
    check("tp1_flow", rx_flow_num_o, 7);
`endif
    pkt(10'd8, 1, 3'd0);
`ifdef PKT_LEN_METER_RUNT_EN
    check("tp_runts", runt_cnt_o, 4);
`else
    check("tp2_en", pkt_size_en_o, 1);
    check("tp2_flow", rx_flow_num_o, 8);
    check("tp2_size", pkt_size_o, 8);
`endif
    idle();

    // reset in the middle of a packet
    rec_base = rec_cnt;
    beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 10'd11);
    beat(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 10'd0);
    pkt_valid_i = 1'b0;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("mrst_flow", rx_flow_num_o, 0);
    check("mrst_size", pkt_size_o, 0);
    check("mrst_en", pkt_size_en_o, 0);
    check("mrst_err", err_cnt_o, 0);
    check("mrst_runt", runt_cnt_o, 0);
    rst_i = 1'b1;
    beat(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 10'd0);
    check("mrst_eop_err", err_cnt_o, 1);
    check("mrst_eop_en", pkt_size_en_o, 0);
    idle();
    idle();
    check("mrst_recs", rec_cnt - rec_base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
